if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch front end; consumes the current PC from the PC register and reads the instruction bus.
//  Single outstanding transaction, one-entry hold buffer for the IF/ID register.
//  Drives if_stall_o back to flow control so the PC freezes while a fetch is in flight.
//  Obeys the same `FLOW_WORK/`FLOW_STOP/`FLOW_REFRESH flow code as the PC register.
// PARAMETERS
//  CPU_WIDTH    32             data/address width
//  NOP_INST     32'h00000013   instruction presented when nothing valid (addi x0,x0,0)
//  TIMEOUT_CYC  255            max cycles waiting for gnt or rvalid; 0 disables timeout
// PORTS
//  clk            in   1            system clock
//  rst_n          in   1            asynchronous active-low reset
//  flow_if_i      in   FLOW_WIDTH   flow code: WORK / STOP / REFRESH
//  curr_pc_i      in   CPU_WIDTH    current PC from PC register
//  ibus_req_o     out  1            fetch request
//  ibus_addr_o    out  CPU_WIDTH    fetch address
//  ibus_gnt_i     in   1            request accepted
//  ibus_rvalid_i  in   1            read data valid
//  ibus_rdata_i   in   CPU_WIDTH    read data
//  ibus_err_i     in   1            bus error, qualified by rvalid
//  inst_o         out  CPU_WIDTH    instruction to decode
//  inst_pc_o      out  CPU_WIDTH    PC of inst_o
//  inst_valid_o   out  1            inst_o is a real fetched instruction
//  if_stall_o     out  1            combinational: hold PC (fetch outstanding)
//  fetch_err_o    out  1            one-cycle pulse on bus error or timeout
// BEHAVIOUR
//  Reset: state IDLE, ibus_req_o=0, inst_o=NOP_INST, inst_pc_o=0, inst_valid_o=0, fetch_err_o=0, timer=0.
//  States: IDLE, REQ, RESP, HOLD, DROP.
//  - IDLE: WORK -> REQ next cycle; STOP/REFRESH -> stay.
//  - REQ: ibus_req_o=1, ibus_addr_o=curr_pc_i (stable, PC frozen by stall). gnt -> latch addr as issue_pc, go RESP.
//  - RESP: wait rvalid. On rvalid with WORK: inst_o<=rdata, inst_pc_o<=issue_pc, inst_valid_o<=1, go REQ.
//    On rvalid with STOP: rdata/issue_pc into pend buffer, inst_o unchanged, go HOLD.
//  - HOLD: WORK -> inst_o/inst_pc_o<=pend, inst_valid_o<=1, go REQ; STOP -> stay.
//  - DROP: wait rvalid, discard data, go IDLE.
//  Throughput: back-to-back fetch; req re-asserts the cycle after rvalid (min 2 cycles/instruction with gnt and rvalid 1 cycle apart).
//  if_stall_o = (REQ) | (RESP & !rvalid) | DROP; 0 in IDLE and HOLD.
//  ibus_req_o only leaves 1 on gnt or REFRESH/timeout; ibus_addr_o is don't-care when req=0 (drive 0).
//  REFRESH (highest priority, any state): inst_o<=NOP_INST, inst_pc_o<=0, inst_valid_o<=0, pend dropped.
//    REQ->IDLE (request withdrawn before gnt; REQ with gnt same cycle -> DROP); RESP->DROP, or IDLE if rvalid same cycle; HOLD->IDLE; DROP stays.
//  Timer: counts cycles in REQ/RESP, cleared on state change. When it reaches TIMEOUT_CYC: fetch_err_o pulse,
//    inst_o<=NOP_INST, inst_valid_o<=0; REQ->IDLE, RESP->DROP. Priority REFRESH > timeout > rvalid/gnt.
//  rvalid with ibus_err_i=1 in RESP: fetch_err_o pulse, inst_o<=NOP_INST, inst_valid_o<=0, inst_pc_o<=issue_pc, go IDLE.
//  STOP in REQ/RESP does not abort; effect only at rvalid (RESP->HOLD).
//  Stray rvalid in IDLE/REQ/HOLD: ignored.
//  Reset mid-transaction: immediate return to reset state; any later rvalid ignored.
// TESTING
//  Reset, WORK, curr_pc=0, gnt 1 cycle after req, rvalid next -> req@0, inst_o=rdata, inst_pc_o=0, valid=1, req re-asserts next cycle.
//  gnt delayed 3 cycles -> ibus_addr_o stable, if_stall_o=1 throughout, single transaction.
//  STOP during RESP, rvalid rdata=32'h00500093 -> inst_o unchanged, HOLD; WORK -> inst_o=32'h00500093.
//  REFRESH while in RESP, rvalid 2 cycles later -> data discarded, inst_o=NOP, valid=0, next req@0.
//  TIMEOUT_CYC=4, no gnt -> fetch_err_o pulse on 4th cycle, req drops, re-requests next cycle.
//  rvalid with ibus_err_i=1 -> fetch_err_o 1 cycle, inst_o=32'h00000013, inst_valid_o=0.

Source files
------------

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch front end. Issues one bus read at a time for the PC
//   presented by the PC register, and loads the returned word into the
//   IF/ID output register. A one-entry hold buffer keeps a word that arrives
//   while decode is stalled. if_stall_o tells flow control to freeze the PC
//   while a fetch is in flight.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   flow_if_i      flow code: FLOW_WORK / FLOW_STOP / FLOW_REFRESH
//   curr_pc_i      current PC from the PC register
//   ibus_req_o     fetch request
//   ibus_addr_o    fetch address (0 when no request)
//   ibus_gnt_i     request accepted
//   ibus_rvalid_i  read data valid
//   ibus_rdata_i   read data
//   ibus_err_i     bus error, qualified by ibus_rvalid_i
//   inst_o         instruction to decode (NOP_INST when nothing valid)
//   inst_pc_o      PC of inst_o
//   inst_valid_o   inst_o is a real fetched instruction
//   if_stall_o     combinational: hold PC while a fetch is outstanding
//   fetch_err_o    one-cycle pulse on bus error or timeout
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; wait for WORK
// REQ    | request on the bus, waiting for grant
// RESP   | granted, waiting for read data
// HOLD   | data parked in the hold buffer while decode is stopped
// DROP   | flushed transaction still owed an rvalid; discard it
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter int                      CPU_WIDTH    = 32,
    parameter logic [CPU_WIDTH-1:0]    NOP_INST     = 32'h00000013,
    parameter int                      TIMEOUT_CYC  = 255,
    parameter int                      FLOW_WIDTH   = 2,
    parameter logic [FLOW_WIDTH-1:0]   FLOW_WORK    = 2'd0,
    parameter logic [FLOW_WIDTH-1:0]   FLOW_STOP    = 2'd1,
    parameter logic [FLOW_WIDTH-1:0]   FLOW_REFRESH = 2'd2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOW_WIDTH-1:0] flow_if_i,
    input  logic [CPU_WIDTH-1:0]  curr_pc_i,
    output logic                  ibus_req_o,
    output logic [CPU_WIDTH-1:0]  ibus_addr_o,
    input  logic                  ibus_gnt_i,
    input  logic                  ibus_rvalid_i,
    input  logic [CPU_WIDTH-1:0]  ibus_rdata_i,
    input  logic                  ibus_err_i,
    output logic [CPU_WIDTH-1:0]  inst_o,
    output logic [CPU_WIDTH-1:0]  inst_pc_o,
    output logic                  inst_valid_o,
    output logic                  if_stall_o,
    output logic                  fetch_err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    // Timer holds the number of cycles already spent in the current REQ/RESP
    // wait, so the timeout fires during the TIMEOUT_CYC-th cycle.
    localparam int            TW       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TW-1:0]        r_timer;
    logic [CPU_WIDTH-1:0] r_issue_pc;
    logic [CPU_WIDTH-1:0] r_pend_inst;
    logic [CPU_WIDTH-1:0] r_pend_pc;

    logic w_work;
    logic w_refresh;
    logic w_busy;
    logic w_timeout;

    assign w_work    = (flow_if_i == FLOW_WORK);
    assign w_refresh = (flow_if_i == FLOW_REFRESH);
    assign w_busy    = (r_state == S_REQ) || (r_state == S_RESP);
    assign w_timeout = (TIMEOUT_CYC != 0) && w_busy && (r_timer == TMO_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_work) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // A grant taken in the same cycle as a refresh still owes an rvalid.
                if (w_refresh)       w_state_nxt = ibus_gnt_i ? S_DROP : S_IDLE;
                else if (w_timeout)  w_state_nxt = S_IDLE;
                else if (ibus_gnt_i) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_refresh)          w_state_nxt = ibus_rvalid_i ? S_IDLE : S_DROP;
                else if (w_timeout)     w_state_nxt = S_DROP;
                else if (ibus_rvalid_i) begin
                    if (ibus_err_i)     w_state_nxt = S_IDLE;
                    else if (w_work)    w_state_nxt = S_REQ;
                    else                w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_refresh)   w_state_nxt = S_IDLE;
                else if (w_work) w_state_nxt = S_REQ;
            end
            S_DROP: begin
                if (ibus_rvalid_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- combinational outputs ----------------
    always_comb begin
        ibus_req_o  = 1'b0;
        ibus_addr_o = '0;
        if_stall_o  = 1'b0;
        case (r_state)
            S_REQ: begin
                ibus_req_o  = 1'b1;
                ibus_addr_o = curr_pc_i;
                if_stall_o  = 1'b1;
            end
            S_RESP:  if_stall_o = !ibus_rvalid_i;
            S_DROP:  if_stall_o = 1'b1;
            default: if_stall_o = 1'b0;
        endcase
    end

    // ---------------- wait timer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!w_busy || (w_state_nxt != r_state)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // ---------------- IF/ID register, hold buffer, error pulse ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_o       <= NOP_INST;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            fetch_err_o  <= 1'b0;
            r_issue_pc   <= '0;
            r_pend_inst  <= '0;
            r_pend_pc    <= '0;
        end else begin
            fetch_err_o <= 1'b0;
            if (w_refresh) begin
                inst_o       <= NOP_INST;
                inst_pc_o    <= '0;
                inst_valid_o <= 1'b0;
            end else if (w_timeout) begin
                fetch_err_o  <= 1'b1;
                inst_o       <= NOP_INST;
                inst_valid_o <= 1'b0;
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (ibus_gnt_i) r_issue_pc <= curr_pc_i;
                    end
                    S_RESP: begin
                        if (ibus_rvalid_i) begin
                            if (ibus_err_i) begin
                                fetch_err_o  <= 1'b1;
                                inst_o       <= NOP_INST;
                                inst_pc_o    <= r_issue_pc;
                                inst_valid_o <= 1'b0;
                            end else if (w_work) begin
                                inst_o       <= ibus_rdata_i;
                                inst_pc_o    <= r_issue_pc;
                                inst_valid_o <= 1'b1;
                            end else begin
                                r_pend_inst  <= ibus_rdata_i;
                                r_pend_pc    <= r_issue_pc;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (w_work) begin
                            inst_o       <= r_pend_inst;
                            inst_pc_o    <= r_pend_pc;
                            inst_valid_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch
//   Directed bench for if_fetch with a transaction-level reference model.
//   The model tracks what the fetch unit owes (a request, a response, a
//   parked word, a discarded response) plus the age of the current wait, and
//   one process compares every DUT output against it on each falling edge.
// ----------------------------------------------------------------------------
module tb_if_fetch;

    localparam int          TMO   = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [1:0]  F_WRK = 2'd0;
    localparam logic [1:0]  F_STP = 2'd1;
    localparam logic [1:0]  F_REF = 2'd2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  flow;
    logic [31:0] curr_pc;
    logic        gnt, rvalid, berr;
    logic [31:0] rdata;
    logic        req, inst_valid, stall, ferr;
    logic [31:0] addr, inst, inst_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch #(
        .CPU_WIDTH   (32),
        .NOP_INST    (NOP),
        .TIMEOUT_CYC (TMO),
        .FLOW_WIDTH  (2),
        .FLOW_WORK   (F_WRK),
        .FLOW_STOP   (F_STP),
        .FLOW_REFRESH(F_REF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flow_if_i    (flow),
        .curr_pc_i    (curr_pc),
        .ibus_req_o   (req),
        .ibus_addr_o  (addr),
        .ibus_gnt_i   (gnt),
        .ibus_rvalid_i(rvalid),
        .ibus_rdata_i (rdata),
        .ibus_err_i   (berr),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (inst_valid),
        .if_stall_o   (stall),
        .fetch_err_o  (ferr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit          m_want    = 0;   // request owed on the bus
    bit          m_wait    = 0;   // granted, response owed to us
    bit          m_held    = 0;   // word parked for a stopped decode
    bit          m_discard = 0;   // flushed response still to come
    int          m_age     = 0;   // cycles already spent in the current wait
    logic [31:0] m_inst    = NOP;
    logic [31:0] m_pc      = 32'h0;
    bit          m_valid   = 0;
    bit          m_err     = 0;
    logic [31:0] m_issue   = 32'h0;
    logic [31:0] m_pend    = 32'h0;
    logic [31:0] m_pend_pc = 32'h0;

    initial begin : model
        bit ow, oa, oh, od, rf, wk, tmo;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_want = 0; m_wait = 0; m_held = 0; m_discard = 0; m_age = 0;
                m_inst = NOP; m_pc = 0; m_valid = 0; m_err = 0;
                m_issue = 0; m_pend = 0; m_pend_pc = 0;
            end else begin
                ow = m_want; oa = m_wait; oh = m_held; od = m_discard;
                rf = (flow == F_REF);
                wk = (flow == F_WRK);
                tmo = (ow || oa) && (m_age + 1 == TMO);
                m_err = 0;
                if (od && rvalid) m_discard = 0;
                if (rf) begin
                    m_inst = NOP; m_pc = 0; m_valid = 0; m_held = 0;
                    if (ow) begin m_want = 0; m_discard = gnt; end
                    if (oa) begin m_wait = 0; m_discard = !rvalid; end
                end else if (tmo) begin
                    m_err = 1; m_inst = NOP; m_valid = 0;
                    if (ow) m_want = 0;
                    else begin m_wait = 0; m_discard = 1; end
                end else if (ow) begin
                    if (gnt) begin m_want = 0; m_wait = 1; m_issue = curr_pc; end
                end else if (oa) begin
                    if (rvalid) begin
                        m_wait = 0;
                        if (berr) begin
                            m_err = 1; m_inst = NOP; m_valid = 0; m_pc = m_issue;
                        end else if (wk) begin
                            m_inst = rdata; m_pc = m_issue; m_valid = 1; m_want = 1;
                        end else begin
                            m_held = 1; m_pend = rdata; m_pend_pc = m_issue;
                        end
                    end
                end else if (oh) begin
                    if (wk) begin
                        m_inst = m_pend; m_pc = m_pend_pc; m_valid = 1;
                        m_held = 0; m_want = 1;
                    end
                end else if (!od) begin
                    if (wk) m_want = 1;
                end
                m_age = ((ow && m_want) || (oa && m_wait)) ? m_age + 1 : 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            check("m_inst",    inst,    m_inst);
            check("m_inst_pc", inst_pc, m_pc);
            check("m_valid",   32'(inst_valid), 32'(m_valid));
            check("m_err",     32'(ferr),       32'(m_err));
            check("m_req",     32'(req),        32'(m_want));
            check("m_addr",    addr,    m_want ? curr_pc : 32'h0);
            check("m_stall",   32'(stall),
                  32'(m_want || (m_wait && !rvalid) || m_discard));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        flow = F_STP; curr_pc = 0; gnt = 0; rvalid = 0; berr = 0; rdata = 0;
        repeat (2) tick();
        check("rst_inst",  inst, NOP);
        check("rst_pc",    inst_pc, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_req",   32'(req), 32'h0);
        check("rst_err",   32'(ferr), 32'h0);
        rst_n = 1;

        // basic fetch: gnt one cycle after req, rvalid next
        flow = F_WRK; tick();
        check("t1_req",  32'(req), 32'h1);
        check("t1_addr", addr, 32'h0);
        gnt = 1; tick();
        gnt = 0; rvalid = 1; rdata = 32'h00a00113; tick();
        rvalid = 0;
        check("t1_inst",  inst, 32'h00a00113);
        check("t1_pc",    inst_pc, 32'h0);
        check("t1_valid", 32'(inst_valid), 32'h1);
        check("t1_rereq", 32'(req), 32'h1);

        // delayed grant: address and stall stay put
        curr_pc = 32'h4;
        repeat (2) begin
            tick();
            check("t2_addr",  addr, 32'h4);
            check("t2_stall", 32'(stall), 32'h1);
        end
        gnt = 1; tick(); gnt = 0;
        check("t2_req_off", 32'(req), 32'h0);
        check("t2_stall_r", 32'(stall), 32'h1);
        tick();
        rvalid = 1; rdata = 32'h00108093; tick(); rvalid = 0;
        check("t2_inst", inst, 32'h00108093);
        check("t2_pc",   inst_pc, 32'h4);

        // STOP at response time parks the word
        curr_pc = 32'h8; gnt = 1; tick();
        gnt = 0; flow = F_STP; rvalid = 1; rdata = 32'h00500093; tick(); rvalid = 0;
        check("t3_hold_inst", inst, 32'h00108093);
        check("t3_hold_req",  32'(req), 32'h0);
        check("t3_hold_stl",  32'(stall), 32'h0);
        tick();
        check("t3_hold_inst2", inst, 32'h00108093);
        flow = F_WRK; tick();
        check("t3_inst",  inst, 32'h00500093);
        check("t3_pc",    inst_pc, 32'h8);
        check("t3_valid", 32'(inst_valid), 32'h1);
        check("t3_req",   32'(req), 32'h1);

        // REFRESH while waiting for data; rvalid two cycles later is dropped
        curr_pc = 32'hc; gnt = 1; tick();
        gnt = 0; flow = F_REF; tick();
        check("t4_inst",  inst, NOP);
        check("t4_valid", 32'(inst_valid), 32'h0);
        check("t4_pc",    inst_pc, 32'h0);
        flow = F_WRK; curr_pc = 32'h0; tick();
        check("t4_drop_stl", 32'(stall), 32'h1);
        rvalid = 1; rdata = 32'hdeadbeef; tick(); rvalid = 0;
        check("t4_discard", inst, NOP);
        tick();
        check("t4_req",  32'(req), 32'h1);
        check("t4_addr", addr, 32'h0);

        // bus error on the response
        gnt = 1; tick();
        gnt = 0; rvalid = 1; berr = 1; rdata = 32'h12345678; tick();
        rvalid = 0; berr = 0; flow = F_STP;
        check("t5_err",   32'(ferr), 32'h1);
        check("t5_inst",  inst, 32'h00000013);
        check("t5_valid", 32'(inst_valid), 32'h0);
        tick();
        check("t5_err_end", 32'(ferr), 32'h0);

        // no grant: timeout after four request cycles
        flow = F_WRK; tick();
        check("t6_req1", 32'(req), 32'h1);
        repeat (3) begin
            tick();
            check("t6_req_on", 32'(req), 32'h1);
            check("t6_no_err", 32'(ferr), 32'h0);
        end
        tick();
        check("t6_req_drop", 32'(req), 32'h0);
        check("t6_err",      32'(ferr), 32'h1);
        tick();
        check("t6_rereq",   32'(req), 32'h1);
        check("t6_err_end", 32'(ferr), 32'h0);

        // no rvalid: timeout in response wait goes to discard
        gnt = 1; tick(); gnt = 0;
        repeat (3) tick();
        tick();
        check("t7_err",   32'(ferr), 32'h1);
        check("t7_stall", 32'(stall), 32'h1);
        flow = F_STP; rvalid = 1; rdata = 32'h0badf00d; tick(); rvalid = 0;
        check("t7_idle_stl", 32'(stall), 32'h0);
        check("t7_inst",     inst, NOP);

        // stray rvalid in IDLE is ignored
        rvalid = 1; rdata = 32'h11111111; tick(); rvalid = 0;
        check("t8_stray_valid", 32'(inst_valid), 32'h0);

        // REFRESH in REQ with grant in the same cycle owes a discard
        flow = F_WRK; tick();
        flow = F_REF; gnt = 1; tick(); gnt = 0; flow = F_STP;
        check("t9_drop_req", 32'(req), 32'h0);
        check("t9_drop_stl", 32'(stall), 32'h1);
        rvalid = 1; tick(); rvalid = 0;
        check("t9_idle_stl", 32'(stall), 32'h0);

        // reset mid-transaction, later rvalid ignored
        flow = F_WRK; tick();
        gnt = 1; tick(); gnt = 0;
        rst_n = 0; #1;
        check("t10_rst_req", 32'(req), 32'h0);
        tick();
        rst_n = 1; flow = F_STP; rvalid = 1; rdata = 32'haaaaaaaa; tick(); rvalid = 0;
        check("t10_inst",  inst, NOP);
        check("t10_valid", 32'(inst_valid), 32'h0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
